reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Consumes the one-shot reset-injection request raised after power-on reset.
- Runs the 6502-style 7-cycle reset sequence: two dummy PC reads, three suppressed stack "pushes" (reads only, SP decremented), then vector fetch from $FFFC/$FFFD.
- Ends with a PC load, an SP load and an I-flag set.
- Sits beside the instruction decoder and halts it while busy; the decoder resumes at the loaded vector.

Parameters:
- STACK_PAGE, 8'h01, high address byte for stack accesses.
- RESET_VECTOR, 16'hFFFC, address of the vector low byte; the high byte is at RESET_VECTOR+1.

Ports:
- clk  in  1  system clock
- nrst  in  1  synchronous active-low reset, sampled on rising clk
- enableFFs  in  1  CPU cycle enable; all state advance and register updates are gated by it
- resetInjection  in  1  level request; high means a reset sequence is pending
- pcIn  in  16  current program counter, used as the dummy-read address
- spIn  in  8  current stack pointer, captured at sequence start
- dataIn  in  8  data bus read value, valid in the same cycle as addressOut
- addressOut  out  16  bus address driven during the sequence
- rw  out  1  1 = read; always 1, because writes are suppressed
- busy  out  1  high in every non-IDLE state; halts the decoder
- pcOut  out  16  assembled reset vector
- pcLoad  out  1  one enabled-cycle strobe to load pcOut into PC
- spOut  out  8  decremented stack pointer
- spLoad  out  1  strobe to load spOut into SP, coincident with pcLoad
- setIFlag  out  1  strobe to set the interrupt-disable flag, coincident with pcLoad

Behaviour:
- Reset: on a rising clk with nrst=0, go to IDLE; clear the internal sp, vecLo and vecHi registers to 0. Outputs in IDLE: addressOut=16'h0000, rw=1, busy=0, pcOut=0, pcLoad=spLoad=setIFlag=0, spOut=0.
- States: IDLE, DUMMY0, DUMMY1, STK0, STK1, STK2, VECLO, VECHI, LOAD.
- Stepping:
  - Every transition out of a non-IDLE state requires enableFFs=1. With enableFFs=0 the state and all registers hold; outputs stay stable.
  - IDLE to DUMMY0 requires resetInjection=1 and enableFFs=1; sp is captured from spIn on the same edge. The upstream detector clears its request on that same enabled edge, so no double start.
- Order: DUMMY0 -> DUMMY1 -> STK0 -> STK1 -> STK2 -> VECLO -> VECHI -> LOAD -> IDLE.
- Addresses:
  - DUMMY0 and DUMMY1: pcIn.
  - STK0, STK1, STK2: {STACK_PAGE, sp}; sp decrements on each enabled edge leaving a STK state, wrapping 8'h00 to 8'hFF.
  - VECLO: RESET_VECTOR.
  - VECHI: RESET_VECTOR+1.
  - LOAD: RESET_VECTOR+1, held.
- Data capture: vecLo is latched from dataIn on the enabled edge leaving VECLO; vecHi is latched on the enabled edge leaving VECHI.
- LOAD outputs: pcOut={vecHi,vecLo}, spOut=sp, pcLoad=spLoad=setIFlag=enableFFs. The strobes are high for exactly one enabled cycle. pcOut and spOut hold their values in all states (reset to 0 only).
- Latency: with enableFFs tied high, LOAD occupies cycle 8 after start, busy is high for 8 cycles, and IDLE is re-entered on cycle 9.
- resetInjection in any non-IDLE state is ignored. If it is still high on return to IDLE, a new sequence starts on the next enabled IDLE cycle.
- nrst=0 mid-sequence aborts to IDLE immediately at that edge. No strobes are issued, and registers take their reset values.
- rw is constant 1; the block never drives a write.

Decomposition:
- Shared control package holds:
  - the state enum;
  - STACK_PAGE_DEFAULT (8'h01);
  - RESET_VECTOR_DEFAULT (16'hFFFC);
  - NMI_VECTOR (16'hFFFA) and IRQ_VECTOR (16'hFFFE), for the later interrupt sequencer that will reuse the state enum.
- No sub-module needed. Single module: a state register, a next-state block, and a datapath for the sp, vecLo and vecHi registers.

Test Plan:
- Basic sequence, enableFFs=1, spIn=8'hFD, pcIn=16'h1234, memory $FFFC=8'h00, $FFFD=8'h80 → addresses 1234, 1234, 01FD, 01FC, 01FB, FFFC, FFFD; then pcOut=16'h8000, spOut=8'hFA, and pcLoad/spLoad/setIFlag high for exactly 1 cycle; busy high for 8 cycles.
- Stall: enableFFs toggles 1,0,0,1,… through the sequence → each state holds while enable=0; the address sequence is identical to the basic case; strobes fire only in the enabled LOAD cycle.
- SP wrap: spIn=8'h01 → stack addresses 0101, 0100, 01FF; spOut=8'hFE.
- Start gating: resetInjection=1 with enableFFs=0 for 5 cycles → busy stays 0; the first enabled cycle enters DUMMY0.
- Abort: nrst=0 during VECLO → next cycle busy=0, no pcLoad; a new request then runs the full sequence from DUMMY0.
- Re-trigger: resetInjection held high through completion → a second sequence starts on the enabled cycle after returning to IDLE; resetInjection pulses mid-sequence → ignored.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared control definitions for the CPU reset and interrupt sequencers.
// State enum, default addresses and the fixed step order.
package reset_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DUMMY0,
    S_DUMMY1,
    S_STK0,
    S_STK1,
    S_STK2,
    S_VECLO,
    S_VECHI,
    S_LOAD
  } seq_state_t;

  localparam logic [7:0]  STACK_PAGE_DEFAULT   = 8'h01;
  localparam logic [15:0] RESET_VECTOR_DEFAULT = 16'hFFFC;
  localparam logic [15:0] NMI_VECTOR           = 16'hFFFA;
  localparam logic [15:0] IRQ_VECTOR           = 16'hFFFE;

  // Successor in the fixed 7-cycle sequence; IDLE is left only on request.
  function automatic seq_state_t next_step(seq_state_t s);
    seq_state_t n;
    n = S_IDLE;
    case (s)
      S_DUMMY0: n = S_DUMMY1;
      S_DUMMY1: n = S_STK0;
      S_STK0:   n = S_STK1;
      S_STK1:   n = S_STK2;
      S_STK2:   n = S_VECLO;
      S_VECLO:  n = S_VECHI;
      S_VECHI:  n = S_LOAD;
      default:  n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bus and control bundle between the reset sequencer and the CPU core.
// master = sequencer side, slave = core side.
interface reset_sequencer_if;

  logic        enableFFs;
  logic        resetInjection;
  logic [15:0] pcIn;
  logic [7:0]  spIn;
  logic [7:0]  dataIn;
  logic [15:0] addressOut;
  logic        rw;
  logic        busy;
  logic [15:0] pcOut;
  logic        pcLoad;
  logic [7:0]  spOut;
  logic        spLoad;
  logic        setIFlag;

  modport master (
    input  enableFFs,
    input  resetInjection,
    input  pcIn,
    input  spIn,
    input  dataIn,
    output addressOut,
    output rw,
    output busy,
    output pcOut,
    output pcLoad,
    output spOut,
    output spLoad,
    output setIFlag
  );

  modport slave (
    output enableFFs,
    output resetInjection,
    output pcIn,
    output spIn,
    output dataIn,
    input  addressOut,
    input  rw,
    input  busy,
    input  pcOut,
    input  pcLoad,
    input  spOut,
    input  spLoad,
    input  setIFlag
  );

endinterface

// File: rtl/reset_sequencer.sv
// 6502-style 7-cycle reset sequence: dummy reads, suppressed pushes,
// vector fetch, then PC/SP load and I-flag set. Halts the decoder while busy.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE   = STACK_PAGE_DEFAULT,
  parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input logic               clk,
  input logic               nrst,
  reset_sequencer_if.master bus
);

  seq_state_t state;
  logic [7:0] sp;
  logic [7:0] vec_lo;
  logic [7:0] vec_hi;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= S_IDLE;
      sp     <= 8'h00;
      vec_lo <= 8'h00;
      vec_hi <= 8'h00;
    end else if (bus.enableFFs) begin
      case (state)
        S_IDLE: begin
          if (bus.resetInjection) begin
            state <= S_DUMMY0;
            sp    <= bus.spIn;
          end
        end
        // Pushes are read-only; only the pointer moves.
        S_STK0, S_STK1, S_STK2: begin
          sp    <= sp - 8'd1;
          state <= next_step(state);
        end
        S_VECLO: begin
          vec_lo <= bus.dataIn;
          state  <= next_step(state);
        end
        S_VECHI: begin
          vec_hi <= bus.dataIn;
          state  <= next_step(state);
        end
        default: state <= next_step(state);
      endcase
    end
  end

  always_comb begin
    bus.addressOut = 16'h0000;
    case (state)
      S_DUMMY0, S_DUMMY1:
        bus.addressOut = bus.pcIn;
      S_STK0, S_STK1, S_STK2:
        bus.addressOut = {STACK_PAGE, sp};
      S_VECLO:
        bus.addressOut = RESET_VECTOR;
      S_VECHI, S_LOAD:
        bus.addressOut = RESET_VECTOR + 16'd1;
      default:
        bus.addressOut = 16'h0000;
    endcase
  end

  logic load_now;
  assign load_now     = (state == S_LOAD) && bus.enableFFs;

  assign bus.rw       = 1'b1;
  assign bus.busy     = (state != S_IDLE);
  assign bus.pcOut    = {vec_hi, vec_lo};
  assign bus.spOut    = sp;
  assign bus.pcLoad   = load_now;
  assign bus.spLoad   = load_now;
  assign bus.setIFlag = load_now;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a sequence-level model predicts
// the bus trace and final loads; a negedge monitor checks the DUT.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  reset_sequencer_if bus();

  reset_sequencer dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0][15:0] addr;
    logic [15:0]      pc;
    logic [7:0]       sp;
  } txn_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cnt = 0;
  txn_t expq[$];
  logic [15:0] seen[$];
  logic [7:0] vlo, vhi;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memory: vector bytes come from vlo/vhi, everything else is filler.
  always_comb begin
    bus.dataIn = bus.addressOut[7:0] ^ 8'h5A;
    if (bus.addressOut == 16'hFFFC) bus.dataIn = vlo;
    if (bus.addressOut == 16'hFFFD) bus.dataIn = vhi;
  end

  function automatic txn_t make_txn(logic [15:0] pc, logic [7:0] sp,
                                    logic [7:0] lo, logic [7:0] hi);
    txn_t t;
    t.addr[0] = pc;
    t.addr[1] = pc;
    t.addr[2] = {8'h01, sp};
    t.addr[3] = {8'h01, sp - 8'd1};
    t.addr[4] = {8'h01, sp - 8'd2};
    t.addr[5] = 16'hFFFC;
    t.addr[6] = 16'hFFFD;
    t.addr[7] = 16'hFFFD;
    t.pc      = {hi, lo};
    t.sp      = sp - 8'd3;
    return t;
  endfunction

  // Reference: a sequence is 8 enabled steps long once started from idle.
  always @(posedge clk) begin
    if (!nrst) begin
      cnt <= 0;
      expq.delete();
    end else if (cnt == 0) begin
      if (bus.resetInjection && bus.enableFFs) begin
        expq.push_back(make_txn(bus.pcIn, bus.spIn, vlo, vhi));
        cnt <= 8;
      end
    end else if (bus.enableFFs) begin
      cnt <= cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      chk("busy", 32'(bus.busy), 32'(cnt > 0));
      chk("pcLoad", 32'(bus.pcLoad), 32'(cnt == 1 && bus.enableFFs));
      chk("rw", 32'(bus.rw), 32'd1);
    end
    if (!bus.busy) seen.delete();
    else if (bus.enableFFs) seen.push_back(bus.addressOut);
    if (bus.pcLoad === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_load", 32'd1, 32'd0);
      end else begin
        txn_t t;
        t = expq.pop_front();
        chk("trace_len", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
          chk($sformatf("addr%0d", i), 32'(seen[i]), 32'(t.addr[i]));
        chk("pcOut", 32'(bus.pcOut), 32'(t.pc));
        chk("spOut", 32'(bus.spOut), 32'(t.sp));
        chk("spLoad", 32'(bus.spLoad), 32'd1);
        chk("setIFlag", 32'(bus.setIFlag), 32'd1);
      end
      seen.delete();
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_seq(logic [15:0] pc, logic [7:0] sp);
    bus.pcIn = pc;
    bus.spIn = sp;
    bus.enableFFs = 1'b1;
    bus.resetInjection = 1'b1;
    tick();
    bus.resetInjection = 1'b0;
  endtask

  task automatic drain();
    bus.enableFFs = 1'b1;
    bus.resetInjection = 1'b0;
    for (int k = 0; k < 40 && cnt != 0; k++) tick();
    chk("drained", 32'(cnt), 32'd0);
    tick();
  endtask

  initial begin
    nrst = 1'b0;
    bus.enableFFs = 1'b0;
    bus.resetInjection = 1'b0;
    bus.pcIn = 16'h0000;
    bus.spIn = 8'h00;
    vlo = 8'h00;
    vhi = 8'h80;
    tick(2);
    @(negedge clk);
    chk("rst_addr", 32'(bus.addressOut), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pcOut", 32'(bus.pcOut), 32'h0);
    chk("rst_spOut", 32'(bus.spOut), 32'h0);
    chk("rst_strobes", 32'({bus.pcLoad, bus.spLoad, bus.setIFlag}), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    tick();

    // Basic sequence
    start_seq(16'h1234, 8'hFD);
    tick(10);
    chk("basic_pc", 32'(bus.pcOut), 32'h8000);
    chk("basic_sp", 32'(bus.spOut), 32'hFA);

    // Stall pattern 1,0,0
    start_seq(16'h1234, 8'hFD);
    for (int i = 0; i < 30; i++) begin
      bus.enableFFs = (i % 3 == 0);
      tick();
    end
    drain();

    // SP wrap
    vlo = 8'h34; vhi = 8'hC2;
    start_seq(16'h4000, 8'h01);
    tick(10);
    chk("wrap_sp", 32'(bus.spOut), 32'hFE);

    // Start gating
    bus.enableFFs = 1'b0;
    bus.resetInjection = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gated_busy", 32'(bus.busy), 32'd0);
    end
    bus.enableFFs = 1'b1;
    tick();
    bus.resetInjection = 1'b0;
    chk("gated_start", 32'(bus.busy), 32'd1);
    drain();

    // Abort during VECLO, then a clean run
    start_seq(16'h2222, 8'h80);
    tick(5);
    chk("abort_addr", 32'(bus.addressOut), 32'hFFFC);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_load", 32'(bus.pcLoad), 32'd0);
    chk("abort_pc", 32'(bus.pcOut), 32'd0);
    start_seq(16'h3333, 8'h40);
    drain();

    // Re-trigger with request held high, then a mid-sequence pulse
    bus.resetInjection = 1'b1;
    bus.enableFFs = 1'b1;
    tick(20);
    drain();
    start_seq(16'h5555, 8'h10);
    tick(2);
    bus.resetInjection = 1'b1;
    tick();
    bus.resetInjection = 1'b0;
    drain();
    chk("pulse_ignored", 32'(bus.busy), 32'd0);

    // Randomized sequences
    for (int it = 0; it < 12; it++) begin
      vlo = 8'($urandom);
      vhi = 8'($urandom);
      bus.pcIn = 16'($urandom);
      bus.spIn = 8'($urandom);
      for (int c = 0; c < 30; c++) begin
        bus.enableFFs = ($urandom_range(0, 2) != 0);
        bus.resetInjection = (cnt == 0) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 4) == 0);
        tick();
        if (cnt != 0) begin
          bus.pcIn = bus.pcIn;
        end
      end
      drain();
    end

    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
